// File: rtl/bias_sat_vec_fifo.sv
// bias_sat_vec_fifo: per-element bias add with saturate/wrap, frame-last tagging and a vector FIFO
module bias_sat_vec_fifo #(
  parameter int TILE_SIZE = 4,
  parameter int DATA_WIDTH = 16,
  parameter int D = 256,
  parameter int FIFO_DEPTH = 8,
  parameter int AFULL_THRESH = FIFO_DEPTH - 2,
  parameter bit SAT_EN = 1'b1,
  parameter bit PULSE_IN = 1'b0,
  localparam int VW = TILE_SIZE * DATA_WIDTH,
  localparam int AW = $clog2(D),
  localparam int LW = $clog2(FIFO_DEPTH + 1)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [VW-1:0]                in_vec,
  input  logic                         sof,
  input  logic                         bias_we,
  input  logic [AW-1:0]                bias_waddr,
  input  logic signed [DATA_WIDTH-1:0] bias_wdata,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [VW-1:0]                out_vec,
  output logic                         out_last,
  output logic [LW-1:0]                level,
  output logic                         almost_full,
  output logic                         overflow,
  input  logic                         ovf_clr
);
  localparam int NT = D / TILE_SIZE;
  localparam int TW = NT > 1 ? $clog2(NT) : 1;
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int EW = VW + 1;
  localparam logic [TW-1:0] LAST_T = TW'(NT - 1);
  logic [TW-1:0] tile_q, tile_d, eidx;
  logic [PW-1:0] wr_q, rd_q;
  logic [LW-1:0] level_q, level_d;
  logic ovf_q, ovf_d;
  logic signed [DATA_WIDTH-1:0] bias_q [D];
  logic [EW-1:0] mem_q [FIFO_DEPTH];
  logic [VW-1:0] sum;
  logic full, push, pop, step, drop, last;
  assign full = level_q == LW'(FIFO_DEPTH);
  assign in_ready = PULSE_IN | ~full;
  assign push = in_valid & ~full;
  assign step = in_valid & in_ready;
  assign drop = PULSE_IN & in_valid & full;
  assign out_valid = level_q != '0;
  assign pop = out_valid & out_ready;
  assign eidx = sof ? '0 : tile_q;
  assign last = eidx == LAST_T;
  assign tile_d = last ? '0 : eidx + TW'(1);
  assign level_d = level_q + LW'(push) - LW'(pop);
  assign ovf_d = drop | (ovf_q & ~ovf_clr);
  assign level = level_q;
  assign almost_full = level_q >= LW'(AFULL_THRESH);
  assign overflow = ovf_q;
  assign out_vec = mem_q[rd_q][EW-1:1];
  assign out_last = out_valid & mem_q[rd_q][0];
  for (genvar i = 0; i < TILE_SIZE; i++) begin : g_lane
    logic signed [DATA_WIDTH-1:0] a, b;
    logic [DATA_WIDTH:0] s;
    assign a = in_vec[i*DATA_WIDTH +: DATA_WIDTH];
    assign b = bias_q[AW'(int'(eidx) * TILE_SIZE + i)];
    assign s = {a[DATA_WIDTH-1], a} + {b[DATA_WIDTH-1], b};
    assign sum[i*DATA_WIDTH +: DATA_WIDTH] = (SAT_EN && s[DATA_WIDTH] != s[DATA_WIDTH-1]) ?
      {s[DATA_WIDTH], {(DATA_WIDTH-1){~s[DATA_WIDTH]}}} : s[DATA_WIDTH-1:0];
  end
  // control state: tile counter advances on accept or drop, FIFO pointers, occupancy, sticky overflow
  always_ff @(posedge clk) begin
    if (rst) begin
      tile_q <= '0;
      wr_q <= '0;
      rd_q <= '0;
      level_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      if (step) tile_q <= tile_d;
      if (push) wr_q <= wr_q + PW'(1);
      if (pop) rd_q <= rd_q + PW'(1);
      level_q <= level_d;
      ovf_q <= ovf_d;
    end
  end
  // bias memory: registered writes, so a same-cycle beat still sees the old value
  always_ff @(posedge clk) begin
    if (rst) for (int j = 0; j < D; j++) bias_q[j] <= '0;
    else if (bias_we) bias_q[bias_waddr] <= bias_wdata;
  end
  // FIFO storage holds {lanes, last}; contents are not reset, validity comes from level
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_q] <= {sum, last};
  end
endmodule
